// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage: FSM states, transfer
// size encodings and the default watchdog limit.
package mem_stage_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    localparam logic [3:0] SZ_B = 4'd1;
    localparam logic [3:0] SZ_H = 4'd2;
    localparam logic [3:0] SZ_W = 4'd4;
    localparam logic [3:0] SZ_D = 4'd8;

    localparam int TIMEOUT_DEFAULT = 255;

    function automatic logic size_legal(input logic [3:0] size);
        return (size == SZ_B) || (size == SZ_H) || (size == SZ_W) || (size == SZ_D);
    endfunction

endpackage

// File: rtl/mem_stage_size_mask.sv
// Keeps the low 'size' bytes of a doubleword and zeroes the rest; serves both
// store-data masking and load-data zero-extension.
module mem_size_mask
    import mem_stage_pkg::*;
(
    input  logic [63:0] data_in,
    input  logic [3:0]  size,
    output logic [63:0] data_out
);

    // Only legal sizes are ever issued, so anything else passes through whole.
    always_comb begin
        data_out = data_in;
        case (size)
            SZ_B:    data_out = {56'd0, data_in[7:0]};
            SZ_H:    data_out = {48'd0, data_in[15:0]};
            SZ_W:    data_out = {32'd0, data_in[31:0]};
            default: data_out = data_in;
        endcase
    end

endmodule

// File: rtl/nn_dff.sv
// Codebase register cell: WIDTH-bit D flip-flop with asynchronous active-high
// reset to zero.
module nn_dff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) q <= '0;
        else       q <= d;
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues one data-memory request per load/store, waits for
// the ack under a watchdog, and produces the registered write-back values.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] alu_result_mem,
    input  logic [63:0] Db_mem,
    input  logic [4:0]  Rd_mem,
    input  logic [3:0]  xfer_size_mem,
    input  logic        MemtoReg_mem,
    input  logic        RegWrite_mem,
    input  logic        MemWrite_mem,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    output logic [3:0]  dmem_size,
    input  logic        dmem_ack,
    input  logic [63:0] dmem_rdata,
    output logic        stall_mem,
    output logic [63:0] wb_data,
    output logic [4:0]  Rd_wb,
    output logic        RegWrite_wb,
    output logic        mem_err
);

    localparam logic [7:0] COUNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        state_raw_q;
    logic [7:0]  count_q, count_d;
    logic        dmem_req_q, dmem_req_d;
    logic        dmem_we_q, dmem_we_d;
    logic [63:0] dmem_addr_q, dmem_addr_d;
    logic [63:0] dmem_wdata_q, dmem_wdata_d;
    logic [3:0]  dmem_size_q, dmem_size_d;
    logic [63:0] wb_data_q, wb_data_d;
    logic [4:0]  rd_wb_q, rd_wb_d;
    logic        regwrite_wb_q, regwrite_wb_d;
    logic        mem_err_q, mem_err_d;

    logic        memop, misaligned, bad, start, timeout;
    logic [2:0]  size_m1;
    logic [63:0] wdata_masked, rdata_ext;

    mem_size_mask u_wmask (.data_in(Db_mem),     .size(xfer_size_mem), .data_out(wdata_masked));
    mem_size_mask u_rext  (.data_in(dmem_rdata), .size(dmem_size_q),   .data_out(rdata_ext));

    assign state_q = state_t'(state_raw_q);

    // For legal power-of-two sizes the low address bits must be clear; size 8
    // wraps to 3'b111 which gives the doubleword alignment mask.
    always_comb begin
        memop      = MemtoReg_mem | MemWrite_mem;
        size_m1    = xfer_size_mem[2:0] - 3'd1;
        misaligned = |(alu_result_mem[2:0] & size_m1);
        bad        = memop & (!size_legal(xfer_size_mem) | misaligned);
        start      = (state_q == IDLE) & memop & !bad;
        timeout    = (state_q == REQ) & (count_q == COUNT_LAST) & !dmem_ack;
        stall_mem  = start | ((state_q == REQ) & !dmem_ack & !timeout);
    end

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        dmem_we_d     = dmem_we_q;
        dmem_addr_d   = dmem_addr_q;
        dmem_wdata_d  = dmem_wdata_q;
        dmem_size_d   = dmem_size_q;
        wb_data_d     = wb_data_q;
        rd_wb_d       = rd_wb_q;
        regwrite_wb_d = 1'b0;
        mem_err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = REQ;
                    count_d      = 8'd0;
                    dmem_addr_d  = alu_result_mem;
                    dmem_we_d    = MemWrite_mem;
                    dmem_size_d  = xfer_size_mem;
                    dmem_wdata_d = wdata_masked;
                end else if (bad) begin
                    mem_err_d = 1'b1;
                end else if (!memop) begin
                    wb_data_d     = alu_result_mem;
                    rd_wb_d       = Rd_mem;
                    regwrite_wb_d = RegWrite_mem;
                end
            end
            REQ: begin
                // Upstream is stalled in REQ, so Rd_mem/RegWrite_mem still belong to this op.
                if (dmem_ack) begin
                    state_d = IDLE;
                    if (!dmem_we_q) begin
                        wb_data_d     = rdata_ext;
                        rd_wb_d       = Rd_mem;
                        regwrite_wb_d = RegWrite_mem;
                    end
                end else if (timeout) begin
                    state_d   = IDLE;
                    mem_err_d = 1'b1;
                end else begin
                    count_d = count_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        dmem_req_d = (state_d == REQ);
    end

    nn_dff #(.WIDTH(1))  u_state_ff    (.clk(clk), .reset(reset), .d(state_d),       .q(state_raw_q));
    nn_dff #(.WIDTH(8))  u_count_ff    (.clk(clk), .reset(reset), .d(count_d),       .q(count_q));
    nn_dff #(.WIDTH(1))  u_req_ff      (.clk(clk), .reset(reset), .d(dmem_req_d),    .q(dmem_req_q));
    nn_dff #(.WIDTH(1))  u_we_ff       (.clk(clk), .reset(reset), .d(dmem_we_d),     .q(dmem_we_q));
    nn_dff #(.WIDTH(64)) u_addr_ff     (.clk(clk), .reset(reset), .d(dmem_addr_d),   .q(dmem_addr_q));
    nn_dff #(.WIDTH(64)) u_wdata_ff    (.clk(clk), .reset(reset), .d(dmem_wdata_d),  .q(dmem_wdata_q));
    nn_dff #(.WIDTH(4))  u_size_ff     (.clk(clk), .reset(reset), .d(dmem_size_d),   .q(dmem_size_q));
    nn_dff #(.WIDTH(64)) u_wb_data_ff  (.clk(clk), .reset(reset), .d(wb_data_d),     .q(wb_data_q));
    nn_dff #(.WIDTH(5))  u_rd_wb_ff    (.clk(clk), .reset(reset), .d(rd_wb_d),       .q(rd_wb_q));
    nn_dff #(.WIDTH(1))  u_regwr_ff    (.clk(clk), .reset(reset), .d(regwrite_wb_d), .q(regwrite_wb_q));
    nn_dff #(.WIDTH(1))  u_mem_err_ff  (.clk(clk), .reset(reset), .d(mem_err_d),     .q(mem_err_q));

    assign dmem_req    = dmem_req_q;
    assign dmem_we     = dmem_we_q;
    assign dmem_addr   = dmem_addr_q;
    assign dmem_wdata  = dmem_wdata_q;
    assign dmem_size   = dmem_size_q;
    assign wb_data     = wb_data_q;
    assign Rd_wb       = rd_wb_q;
    assign RegWrite_wb = regwrite_wb_q;
    assign mem_err     = mem_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed scenarios plus randomized ops checked
// against a transaction-level model of the stage's behaviour.
module tb_mem_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] alu_result_mem = '0;
    logic [63:0] Db_mem = '0;
    logic [4:0]  Rd_mem = '0;
    logic [3:0]  xfer_size_mem = '0;
    logic        MemtoReg_mem = 1'b0;
    logic        RegWrite_mem = 1'b0;
    logic        MemWrite_mem = 1'b0;
    logic        dmem_ack = 1'b0;
    logic [63:0] dmem_rdata = '0;
    logic        dmem_req, dmem_we, stall_mem, RegWrite_wb, mem_err;
    logic [63:0] dmem_addr, dmem_wdata, wb_data;
    logic [3:0]  dmem_size;
    logic [4:0]  Rd_wb;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_wb_data = '0;
    logic [4:0]  exp_rd_wb = '0;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .alu_result_mem(alu_result_mem), .Db_mem(Db_mem), .Rd_mem(Rd_mem),
        .xfer_size_mem(xfer_size_mem), .MemtoReg_mem(MemtoReg_mem),
        .RegWrite_mem(RegWrite_mem), .MemWrite_mem(MemWrite_mem),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_size(dmem_size),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stall_mem(stall_mem), .wb_data(wb_data), .Rd_wb(Rd_wb),
        .RegWrite_wb(RegWrite_wb), .mem_err(mem_err)
    );

    function automatic logic [63:0] size_mask(input logic [3:0] size);
        if (size >= 4'd8) return '1;
        return (64'd1 << (8 * size)) - 64'd1;
    endfunction

    function automatic bit is_bad(input logic [63:0] addr, input logic [3:0] size);
        if (!(size == 4'd1 || size == 4'd2 || size == 4'd4 || size == 4'd8)) return 1'b1;
        return (addr % 64'(size)) != 64'd0;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_size, wb_data, Rd_wb, RegWrite_wb, mem_err, stall_mem} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_state got %h exp 0",
                     {dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_size, wb_data, Rd_wb, RegWrite_wb, mem_err, stall_mem});
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_wb_data = '0;
        exp_rd_wb = '0;
    endtask

    task automatic test_nop(input logic [63:0] a, input logic [4:0] rd, input logic rw, input logic stray);
        MemtoReg_mem = 1'b0;
        MemWrite_mem = 1'b0;
        alu_result_mem = a;
        Rd_mem = rd;
        RegWrite_mem = rw;
        Db_mem = {$urandom, $urandom};
        xfer_size_mem = 4'($urandom_range(0, 15));
        dmem_ack = stray;
        dmem_rdata = {$urandom, $urandom};
        #1;
        checks++;
        if (stall_mem !== 1'b0) begin
            errors++;
            $display("[TB] FAIL nop_stall got %b exp 0", stall_mem);
        end
        @(posedge clk);
        #1;
        dmem_ack = 1'b0;
        exp_wb_data = a;
        exp_rd_wb = rd;
        checks++;
        if ({wb_data, Rd_wb, RegWrite_wb} !== {exp_wb_data, exp_rd_wb, rw}) begin
            errors++;
            $display("[TB] FAIL nop_wb got %h/%0d/%b exp %h/%0d/%b", wb_data, Rd_wb, RegWrite_wb, exp_wb_data, exp_rd_wb, rw);
        end
        checks++;
        if ({dmem_req, mem_err} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL nop_req_err got %b%b exp 00", dmem_req, mem_err);
        end
    endtask

    // ack_at: REQ cycle (1-based) in which the ack arrives; 0 means never.
    task automatic test_mem_op(input logic st, input logic [63:0] addr, input logic [3:0] size,
                               input logic [63:0] wd, input logic [63:0] rdata, input int ack_at,
                               input logic [4:0] rd, input logic rw);
        bit bad, acked, fin;
        logic [63:0] mask;
        bad = is_bad(addr, size);
        mask = size_mask(size);
        MemtoReg_mem = !st;
        MemWrite_mem = st;
        alu_result_mem = addr;
        xfer_size_mem = size;
        Db_mem = wd;
        Rd_mem = rd;
        RegWrite_mem = rw;
        dmem_ack = 1'b0;
        dmem_rdata = rdata;
        #1;
        checks++;
        if (stall_mem !== !bad) begin
            errors++;
            $display("[TB] FAIL idle_stall got %b exp %b", stall_mem, !bad);
        end
        @(posedge clk);
        #1;
        if (bad) begin
            checks++;
            if ({dmem_req, mem_err, RegWrite_wb} !== 3'b010) begin
                errors++;
                $display("[TB] FAIL bad_resp req/err/rw got %b%b%b exp 010", dmem_req, mem_err, RegWrite_wb);
            end
            checks++;
            if ({wb_data, Rd_wb} !== {exp_wb_data, exp_rd_wb}) begin
                errors++;
                $display("[TB] FAIL bad_wb_hold got %h/%0d exp %h/%0d", wb_data, Rd_wb, exp_wb_data, exp_rd_wb);
            end
            return;
        end
        acked = 1'b0;
        fin = 1'b0;
        for (int i = 1; i <= TO && !fin; i++) begin
            checks++;
            if ({dmem_req, dmem_we, dmem_addr, dmem_size, dmem_wdata} !== {1'b1, st, addr, size, wd & mask}) begin
                errors++;
                $display("[TB] FAIL req_fields cyc %0d got %b %b %h %0d %h exp 1 %b %h %0d %h", i,
                         dmem_req, dmem_we, dmem_addr, dmem_size, dmem_wdata, st, addr, size, wd & mask);
            end
            checks++;
            if ({RegWrite_wb, mem_err, wb_data, Rd_wb} !== {2'b00, exp_wb_data, exp_rd_wb}) begin
                errors++;
                $display("[TB] FAIL bubble cyc %0d got %b%b %h %0d exp 00 %h %0d", i,
                         RegWrite_wb, mem_err, wb_data, Rd_wb, exp_wb_data, exp_rd_wb);
            end
            acked = (i == ack_at);
            dmem_ack = acked;
            #1;
            checks++;
            if (stall_mem !== !(acked || i == TO)) begin
                errors++;
                $display("[TB] FAIL req_stall cyc %0d got %b exp %b", i, stall_mem, !(acked || i == TO));
            end
            @(posedge clk);
            #1;
            dmem_ack = 1'b0;
            fin = acked || (i == TO);
        end
        checks++;
        if (dmem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL req_drop got %b exp 0", dmem_req);
        end
        if (acked && !st) begin
            exp_wb_data = rdata & mask;
            exp_rd_wb = rd;
            checks++;
            if ({wb_data, Rd_wb, RegWrite_wb, mem_err} !== {exp_wb_data, exp_rd_wb, rw, 1'b0}) begin
                errors++;
                $display("[TB] FAIL load_wb got %h/%0d/%b/%b exp %h/%0d/%b/0", wb_data, Rd_wb, RegWrite_wb, mem_err,
                         exp_wb_data, exp_rd_wb, rw);
            end
        end else begin
            checks++;
            if ({wb_data, Rd_wb, RegWrite_wb, mem_err} !== {exp_wb_data, exp_rd_wb, 1'b0, 1'(!acked)}) begin
                errors++;
                $display("[TB] FAIL store_or_timeout got %h/%0d/%b/%b exp %h/%0d/0/%b", wb_data, Rd_wb, RegWrite_wb, mem_err,
                         exp_wb_data, exp_rd_wb, !acked);
            end
        end
    endtask

    task automatic test_alu();
        test_nop(64'h1234, 5'd3, 1'b1, 1'b0);
    endtask

    task automatic test_load_wait();
        test_mem_op(1'b0, 64'h40, 4'd8, 64'h1111_2222_3333_4444, 64'hDEAD_BEEF_CAFE_F00D, 4, 5'd7, 1'b1);
    endtask

    task automatic test_byte_ops();
        test_mem_op(1'b0, 64'h41, 4'd1, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 1, 5'd9, 1'b1);
        test_mem_op(1'b1, 64'h41, 4'd1, 64'hAABB, 64'h0, 1, 5'd10, 1'b1);
    endtask

    task automatic test_bad_ops();
        test_mem_op(1'b0, 64'h42, 4'd4, 64'h0, 64'h0, 1, 5'd11, 1'b1);
        test_nop(64'h5555, 5'd12, 1'b1, 1'b0);
        test_mem_op(1'b0, 64'h42, 4'd3, 64'h0, 64'h0, 1, 5'd13, 1'b1);
    endtask

    task automatic test_timeout();
        test_mem_op(1'b0, 64'h100, 4'd8, 64'h0, 64'h0, 0, 5'd14, 1'b1);
        test_nop(64'h6666, 5'd15, 1'b1, 1'b1);
    endtask

    task automatic test_reset_in_req();
        MemtoReg_mem = 1'b1;
        MemWrite_mem = 1'b0;
        alu_result_mem = 64'h80;
        xfer_size_mem = 4'd8;
        Rd_mem = 5'd20;
        RegWrite_mem = 1'b1;
        dmem_ack = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (dmem_req !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rst_req_enter got %b exp 1", dmem_req);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_size, wb_data, Rd_wb, RegWrite_wb, mem_err} !== '0) begin
            errors++;
            $display("[TB] FAIL rst_in_req got %h exp 0",
                     {dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_size, wb_data, Rd_wb, RegWrite_wb, mem_err});
        end
        MemtoReg_mem = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_wb_data = '0;
        exp_rd_wb = '0;
        test_mem_op(1'b1, 64'h88, 4'd2, 64'h1234_5678, 64'h0, 2, 5'd21, 1'b1);
        test_nop(64'h7777, 5'd22, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic [3:0]  sz;
        logic [63:0] addr;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                test_nop({$urandom, $urandom}, 5'($urandom), 1'($urandom), 1'($urandom));
            end else begin
                case ($urandom_range(0, 5))
                    0:       sz = 4'd1;
                    1:       sz = 4'd2;
                    2:       sz = 4'd4;
                    4:       sz = 4'($urandom_range(0, 15));
                    default: sz = 4'd8;
                endcase
                addr = {$urandom, $urandom};
                if ((sz == 4'd1 || sz == 4'd2 || sz == 4'd4 || sz == 4'd8) && $urandom_range(0, 3) != 0)
                    addr = addr & ~(64'(sz) - 64'd1);
                test_mem_op(1'($urandom), addr, sz, {$urandom, $urandom}, {$urandom, $urandom},
                            int'($urandom_range(0, TO)), 5'($urandom), 1'($urandom));
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_wait();
        test_byte_ops();
        test_bad_ops();
        test_timeout();
        test_reset_in_req();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
